// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter.
//   SYNC_DEFAULT : default first byte of every frame
//   byte_t       : one FIFO byte
//   state_t      : frame FSM states (IDLE, SYNC, SEQ, DATA, CSUM, GAP)
package uart_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    DATA,
    CSUM,
    GAP
  } state_t;

endpackage

// File: rtl/uart_frame_tx_if.sv
// Write side of one UART TX FIFO.
//   tx_full : FIFO full flag (FIFO -> transmitter)
//   w_data  : byte to write (transmitter -> FIFO)
//   wr_uart : one-cycle write strobe (transmitter -> FIFO)
// The master modport is the frame transmitter; the slave modport is the FIFO.
interface uart_frame_tx_if;
  import uart_pkg::*;

  logic  tx_full;
  byte_t w_data;
  logic  wr_uart;

  modport master (input tx_full, output w_data, output wr_uart);
  modport slave  (output tx_full, input w_data, input wr_uart);

endinterface

// File: rtl/uart_period_tick.sv
// Free-running period counter producing a one-cycle tick.
//   clk, rst : clock and asynchronous active-high reset
//   en       : counter runs while high, is held at 0 while low
//   tick     : high in the cycle the count equals PERIOD_CYCLES-1
module uart_period_tick #(
  parameter int PERIOD_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PERIOD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(PERIOD_CYCLES - 1)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Framed transmitter feeding one UART TX FIFO.
// Emits SYNC, SEQ, NUM_BYTES payload bytes (byte 0 first), CSUM, where
// CSUM = SEQ xor all payload bytes. Frames start on force_send, a periodic
// tick, or (ON_CHANGE) a payload differing from the last frame sent.
//   clk, rst   : clock and asynchronous active-high reset
//   en         : enables the period counter and new triggers
//   payload    : NUM_BYTES*8 payload vector, byte k = payload[8k+7:8k]
//   force_send : single-cycle request for an immediate frame
//   fifo       : FIFO write port (tx_full in, w_data/wr_uart out)
//   busy       : frame in progress
//   seq        : sequence number of the next frame
//   dropped    : one-cycle pulse when a trigger finds one already queued
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int    NUM_BYTES     = 3,
  parameter byte_t SYNC_BYTE     = SYNC_DEFAULT,
  parameter int    PERIOD_CYCLES = 1_000_000,
  parameter int    ON_CHANGE     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_BYTES*8-1:0] payload,
  input  logic                   force_send,
  uart_frame_tx_if.master        fifo,
  output logic                   busy,
  output byte_t                  seq,
  output logic                   dropped
);

  localparam int PW = NUM_BYTES * 8;
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_t        state_q, state_d, next_q, next_d;
  logic [PW-1:0] snap_q, snap_d, last_q, last_d, ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;
  byte_t         csum_q, csum_d, w_data_q, w_data_d, seq_q, seq_d;
  logic          wr_q, wr_d, busy_q, busy_d;
  logic          pending_q, pending_d, dropped_q, dropped_d;
  logic          tick, change_hit, trigger;
  byte_t         data_byte;

  uart_period_tick #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign data_byte = snap_q[{idx_q, 3'b000} +: 8];

  // While idle a change means "differs from the last frame sent". While busy
  // it is edge-like against ref_q so that every distinct mid-frame change
  // counts once, rather than the frozen snapshot re-triggering every cycle.
  assign change_hit = (ON_CHANGE != 0) &&
                      (busy_q ? (payload != ref_q) : (payload != last_q));
  assign trigger    = en && (force_send || tick || change_hit);

  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    snap_d    = snap_q;
    last_d    = last_q;
    ref_d     = ref_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    w_data_d  = w_data_q;
    seq_d     = seq_q;
    busy_d    = busy_q;
    pending_d = pending_q;
    wr_d      = 1'b0;
    dropped_d = 1'b0;

    // Triggers during a frame queue at most one follow-up frame.
    if (trigger && busy_q) begin
      dropped_d = pending_q;
      pending_d = 1'b1;
      ref_d     = payload;
    end

    case (state_q)
      IDLE: begin
        if (trigger || (en && pending_q)) begin
          snap_d    = payload;
          ref_d     = payload;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          idx_d     = '0;
          state_d   = SYNC;
        end
      end
      SYNC: begin
        if (!fifo.tx_full) begin
          w_data_d = SYNC_BYTE;
          wr_d     = 1'b1;
          state_d  = GAP;
          next_d   = SEQ;
        end
      end
      SEQ: begin
        if (!fifo.tx_full) begin
          w_data_d = seq_q;
          csum_d   = seq_q;
          wr_d     = 1'b1;
          state_d  = GAP;
          next_d   = DATA;
        end
      end
      DATA: begin
        if (!fifo.tx_full) begin
          w_data_d = data_byte;
          csum_d   = csum_q ^ data_byte;
          wr_d     = 1'b1;
          state_d  = GAP;
          if (idx_q == IW'(NUM_BYTES - 1)) begin
            idx_d  = '0;
            next_d = CSUM;
          end else begin
            idx_d  = idx_q + 1'b1;
            next_d = DATA;
          end
        end
      end
      CSUM: begin
        if (!fifo.tx_full) begin
          w_data_d = csum_q;
          wr_d     = 1'b1;
          state_d  = GAP;
          next_d   = IDLE;
        end
      end
      GAP: begin
        // One idle cycle lets tx_full reflect the byte just written.
        state_d = next_q;
        if (next_q == IDLE) begin
          last_d = snap_q;
          seq_d  = seq_q + 8'd1;
          busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      next_q    <= IDLE;
      snap_q    <= '0;
      last_q    <= '0;
      ref_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      w_data_q  <= '0;
      seq_q     <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      next_q    <= next_d;
      snap_q    <= snap_d;
      last_q    <= last_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      w_data_q  <= w_data_d;
      seq_q     <= seq_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end

  assign fifo.w_data  = w_data_q;
  assign fifo.wr_uart = wr_q;
  assign busy         = busy_q;
  assign seq          = seq_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx. A frame-level model (expected sequence counter,
// XOR checksum, expected payload) checks every frame collected from the FIFO
// port; a second instance with a short period checks periodic spacing and
// sequence wrap.
module tb_uart_frame_tx;
  import uart_pkg::*;

  localparam int NB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, force_send, busy, dropped;
  logic [NB*8-1:0] payload;
  byte_t         seq;
  logic          full_dir, rand_full, full_rnd;

  logic          en_p, force_p, busy_p, dropped_p;
  logic [NB*8-1:0] payload_p;
  byte_t         seq_p;

  uart_frame_tx_if fifo ();
  uart_frame_tx_if fifo_p ();

  assign fifo.tx_full   = rand_full ? full_rnd : full_dir;
  assign fifo_p.tx_full = 1'b0;

  uart_frame_tx #(.NUM_BYTES(NB), .SYNC_BYTE(8'hA5), .PERIOD_CYCLES(1_000_000), .ON_CHANGE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .payload(payload), .force_send(force_send),
    .fifo(fifo), .busy(busy), .seq(seq), .dropped(dropped)
  );

  uart_frame_tx #(.NUM_BYTES(NB), .SYNC_BYTE(8'hA5), .PERIOD_CYCLES(20), .ON_CHANGE(0)) dut_p (
    .clk(clk), .rst(rst), .en(en_p), .payload(payload_p), .force_send(force_p),
    .fifo(fifo_p), .busy(busy_p), .seq(seq_p), .dropped(dropped_p)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  byte_t got_q[$];
  int    wr_count = 0;
  int    drop_count = 0;
  logic  prev_wr = 1'b0;
  logic  full_at_edge = 1'b0;
  byte_t exp_seq;
  int    cyc = 0;
  int    pos_p = 0;
  int    p_frames = 0;
  int    last_sync_cyc = 0;
  byte_t p_exp_seq = 8'd0;
  logic [NB*8-1:0] rp;
  int    base, drop_base, budget;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NB*8-1:0] p, input logic f);
    payload    = p;
    force_send = f;
    step(1);
    force_send = 1'b0;
  endtask

  task automatic waitWrites(input int target, input string tag);
    int b = 200;
    while (wr_count < target && b > 0) begin
      step(1);
      b--;
    end
    checkOutput({tag, "_timeout"}, 32'(wr_count >= target), 1);
  endtask

  task automatic waitIdle(input string tag);
    int b = 200;
    while (busy && b > 0) begin
      step(1);
      b--;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 0);
  endtask

  // Pops one frame and compares it with SYNC, model seq, payload, XOR checksum.
  task automatic expectFrame(input logic [NB*8-1:0] p, input string tag);
    int    b = 400;
    byte_t cs, v;
    while (got_q.size() < NB + 3 && b > 0) begin
      step(1);
      b--;
    end
    checkOutput({tag, "_timeout"}, 32'(got_q.size() >= NB + 3), 1);
    if (got_q.size() >= NB + 3) begin
      cs = exp_seq;
      v = got_q.pop_front();
      checkOutput({tag, "_sync"}, v, 8'hA5);
      v = got_q.pop_front();
      checkOutput({tag, "_seq"}, v, exp_seq);
      for (int k = 0; k < NB; k++) begin
        v = got_q.pop_front();
        checkOutput({tag, "_data"}, v, p[8*k +: 8]);
        cs = cs ^ p[8*k +: 8];
      end
      v = got_q.pop_front();
      checkOutput({tag, "_csum"}, v, cs);
      exp_seq = exp_seq + 8'd1;
    end
  endtask

  always @(negedge clk) full_rnd = ($urandom_range(3) == 0);

  always @(posedge clk) begin
    full_at_edge <= fifo.tx_full;
    cyc <= cyc + 1;
  end

  // FIFO-side monitor of the main instance.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b0;
    end else begin
      if (fifo.wr_uart) begin
        checkOutput("wr_after_full", 32'(full_at_edge), 0);
        checkOutput("wr_spacing", 32'(prev_wr), 0);
        got_q.push_back(fifo.w_data);
        wr_count++;
      end
      if (dropped) drop_count++;
      prev_wr = fifo.wr_uart;
    end
  end

  // Periodic instance: SYNC every 20 cycles, seq byte counts and wraps.
  always @(negedge clk) begin
    if (en_p && fifo_p.wr_uart) begin
      if (pos_p == 0) begin
        checkOutput("per_sync", fifo_p.w_data, 8'hA5);
        if (p_frames > 0) checkOutput("per_interval", 32'(cyc - last_sync_cyc), 20);
        last_sync_cyc = cyc;
      end else if (pos_p == 1) begin
        checkOutput("per_seq", fifo_p.w_data, p_exp_seq);
        p_exp_seq = p_exp_seq + 8'd1;
      end
      if (pos_p == NB + 2) begin
        pos_p = 0;
        p_frames++;
      end else begin
        pos_p++;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; force_send = 1'b0; payload = '0;
    full_dir = 1'b0; rand_full = 1'b0;
    en_p = 1'b0; force_p = 1'b0; payload_p = 24'h5A5A5A;
    exp_seq = 8'd0;
    step(3);
    checkOutput("rst_wdata", fifo.w_data, 8'h00);
    checkOutput("rst_wr", 32'(fifo.wr_uart), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_seq", seq, 8'h00);
    checkOutput("rst_dropped", 32'(dropped), 0);
    checkOutput("rst_cnt", 32'(dut.u_tick.cnt_q), 0);
    rst = 1'b0;
    step(2);

    // Basic frame: A5,00,01,02,03,00
    en = 1'b1;
    step(3);
    checkOutput("idle_no_frame", wr_count, 0);
    applyStimulus(24'h030201, 1'b1);
    expectFrame(24'h030201, "t1");
    waitIdle("t1");
    checkOutput("t1_seq", seq, 8'd1);

    // tx_full held for 10 cycles in front of DATA byte 1
    base = wr_count;
    applyStimulus(24'h030201, 1'b1);
    waitWrites(base + 3, "t2_pre");
    full_dir = 1'b1;
    step(10);
    checkOutput("t2_hold", wr_count, base + 3);
    full_dir = 1'b0;
    step(1);
    checkOutput("t2_resume", wr_count, base + 4);
    checkOutput("t2_byte", (got_q.size() > 0) ? got_q[$] : 8'hFF, 8'h02);
    expectFrame(24'h030201, "t2");
    waitIdle("t2");

    // Two payload changes mid-frame: one follow-up frame, one dropped pulse
    drop_base = drop_count;
    base = wr_count;
    applyStimulus(24'h112233, 1'b1);
    waitWrites(base + 2, "t3_pre");
    payload = 24'h445566;
    step(2);
    payload = 24'h778899;
    step(2);
    expectFrame(24'h112233, "t3_first");
    expectFrame(24'h778899, "t3_follow");
    waitIdle("t3");
    step(20);
    checkOutput("t3_extra", got_q.size(), 0);
    checkOutput("t3_dropped", drop_count - drop_base, 1);

    // Asynchronous reset in the middle of DATA
    base = wr_count;
    applyStimulus(24'hC0FFEE, 1'b1);
    waitWrites(base + 3, "t5_pre");
    rst = 1'b1;
    #1;
    checkOutput("t5_wr", 32'(fifo.wr_uart), 0);
    checkOutput("t5_wdata", fifo.w_data, 8'h00);
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_seq", seq, 8'h00);
    en = 1'b0;
    step(2);
    rst = 1'b0;
    got_q.delete();
    exp_seq = 8'd0;
    step(1);
    en = 1'b1;
    applyStimulus(24'hC0FFEE, 1'b1);
    expectFrame(24'hC0FFEE, "t5_after");
    waitIdle("t5");
    step(10);
    checkOutput("t5_extra", got_q.size(), 0);

    // en=0: no activity, counter held at 0
    base = wr_count;
    en = 1'b0;
    step(1);
    for (int i = 0; i < 30; i++) begin
      payload    = NB*8'($urandom);
      force_send = i[0];
      step(1);
    end
    force_send = 1'b0;
    checkOutput("t6_no_wr", wr_count, base);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_cnt", 32'(dut.u_tick.cnt_q), 0);
    payload = 24'h0A0B0C;
    en = 1'b1;
    expectFrame(24'h0A0B0C, "t6_resume");
    waitIdle("t6");

    // Randomized payloads with random FIFO back-pressure
    rand_full = 1'b1;
    for (int it = 0; it < 25; it++) begin
      rp = NB*8'($urandom);
      applyStimulus(rp, 1'b1);
      expectFrame(rp, "rand");
      waitIdle("rand");
    end
    rand_full = 1'b0;
    step(5);
    checkOutput("rand_seq", seq, exp_seq);

    // Periodic instance: held counter, then 258 frames
    checkOutput("per_cnt_held", 32'(dut_p.u_tick.cnt_q), 0);
    en_p = 1'b1;
    budget = 258 * 20 + 100;
    while (p_frames < 258 && budget > 0) begin
      step(1);
      budget--;
    end
    checkOutput("per_timeout", 32'(p_frames >= 258), 1);
    en_p = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
